// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC and the instruction register, and runs
// a req/ready handshake with instruction memory on behalf of the control unit.
module instr_fetch_unit #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_read,
  input  logic            pc_write,
  input  logic [XLEN-1:0] pc_next,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     instru,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] pc,
  output logic            instr_valid,
  output logic            fetch_busy,
  output logic            fault_misaligned
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic         start_fetch;
  logic         capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // mem_req is decoded from the state register so that reset drops it immediately.
  always_comb begin
    state_nxt   = state;
    start_fetch = 1'b0;
    capture     = 1'b0;
    mem_req     = 1'b0;
    case (state)
      IDLE: begin
        if (imem_read) begin
          start_fetch = 1'b1;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The fetch address is latched at request start, so PC writes never disturb an in-flight fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr    <= RESET_PC;
      instru      <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else begin
      if (start_fetch) begin
        mem_addr    <= pc;
        instr_valid <= 1'b0;
      end
      if (capture) begin
        instru      <= mem_rdata;
        instr_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc               <= RESET_PC;
      fault_misaligned <= 1'b0;
    end else if (pc_write) begin
      pc <= {pc_next[XLEN-1:2], 2'b00};
      if (pc_next[1:0] != 2'b00) begin
        fault_misaligned <= 1'b1;
      end
    end
  end

  assign opcode     = instru[6:0];
  assign fetch_busy = (state == REQ);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetches compared against a transaction-level model of PC and IR behaviour.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_read;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] instru;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fault_misaligned;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instru;
  logic        m_valid;
  logic        m_fault;

  instr_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_read        (imem_read),
    .pc_write         (pc_write),
    .pc_next          (pc_next),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ready        (mem_ready),
    .mem_rdata        (mem_rdata),
    .instru           (instru),
    .opcode           (opcode),
    .pc               (pc),
    .instr_valid      (instr_valid),
    .fetch_busy       (fetch_busy),
    .fault_misaligned (fault_misaligned)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_pc     = 32'h0;
    m_instru = NOP;
    m_valid  = 1'b0;
    m_fault  = 1'b0;
  endfunction

  function automatic void model_pc_write(input logic [31:0] v);
    m_pc = (v / 4) * 4;
    if ((v % 4) != 0) m_fault = 1'b1;
  endfunction

  task automatic write_pc(input logic [31:0] v);
    pc_write = 1'b1;
    pc_next  = v;
    @(posedge clk); #1;
    pc_write = 1'b0;
    model_pc_write(v);
  endtask

  // Drives one complete fetch and records what was observed during REQ.
  // pw_cycle: -2 no pc write, -1 pc write with imem_read, k>=0 during REQ cycle k.
  task automatic do_fetch(input int waits, input logic [31:0] data,
                          input int pw_cycle, input logic [31:0] pw_val,
                          input bit read_in_req,
                          output logic [31:0] addr0, output bit addr_stable,
                          output int req_cycles, output bit early_valid);
    imem_read = 1'b1;
    pc_write  = (pw_cycle == -1);
    pc_next   = pw_val;
    @(posedge clk); #1;
    imem_read   = read_in_req;
    pc_write    = 1'b0;
    addr0       = mem_addr;
    addr_stable = 1'b1;
    req_cycles  = 0;
    early_valid = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      if (mem_req === 1'b1 && fetch_busy === 1'b1) req_cycles++;
      if (mem_addr !== addr0) addr_stable = 1'b0;
      if (instr_valid !== 1'b0) early_valid = 1'b1;
      mem_ready = (i == waits);
      mem_rdata = (i == waits) ? data : $urandom;
      pc_write  = (pw_cycle == i);
      pc_next   = pw_val;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    pc_write  = 1'b0;
    imem_read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected %h", mem_addr, 32'h0); end
    checks++; if (instru !== NOP) begin errors++; $display("[TB] FAIL reset_instru: got %h expected %h", instru, NOP); end
    checks++; if (opcode !== 7'b0010011) begin errors++; $display("[TB] FAIL reset_opcode: got %b expected %b", opcode, 7'b0010011); end
    checks++; if ({mem_req, instr_valid, fetch_busy, fault_misaligned} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {mem_req, instr_valid, fetch_busy, fault_misaligned});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_fetch();
    logic [31:0] a0; bit st; int rc; bit ev;
    do_fetch(0, 32'h0000_0013, -2, 32'h0, 1'b0, a0, st, rc, ev);
    checks++; if (a0 !== 32'h0) begin errors++; $display("[TB] FAIL basic_addr: got %h expected %h", a0, 32'h0); end
    checks++; if (rc !== 1) begin errors++; $display("[TB] FAIL basic_req_cycles: got %0d expected 1", rc); end
    checks++; if (instru !== 32'h13 || opcode !== 7'b0010011) begin errors++; $display("[TB] FAIL basic_instru: got %h/%b expected 00000013/0010011", instru, opcode); end
    checks++; if (instr_valid !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL basic_done: got valid=%b req=%b expected valid=1 req=0", instr_valid, mem_req); end
    m_instru = 32'h13; m_valid = 1'b1;
  endtask

  task automatic test_wait_states();
    logic [31:0] a0; bit st; int rc; bit ev;
    do_fetch(3, 32'h0020_8133, -2, 32'h0, 1'b0, a0, st, rc, ev);
    checks++; if (rc !== 4) begin errors++; $display("[TB] FAIL wait_req_cycles: got %0d expected 4", rc); end
    checks++; if (!st || a0 !== m_pc) begin errors++; $display("[TB] FAIL wait_addr_stable: got addr %h stable=%0d expected %h stable=1", a0, st, m_pc); end
    checks++; if (ev) begin errors++; $display("[TB] FAIL wait_early_valid: got 1 expected 0"); end
    checks++; if (instru !== 32'h0020_8133 || instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL wait_instru: got %h v=%b expected 00208133 v=1", instru, instr_valid); end
    m_instru = 32'h0020_8133; m_valid = 1'b1;
  endtask

  task automatic test_pc_write_fetch();
    logic [31:0] a0; bit st; int rc; bit ev;
    write_pc(32'h104);
    checks++; if (pc !== 32'h104) begin errors++; $display("[TB] FAIL pcw_pc: got %h expected 00000104", pc); end
    do_fetch(1, 32'h1234_5677, -2, 32'h0, 1'b0, a0, st, rc, ev);
    checks++; if (a0 !== 32'h104 || !st) begin errors++; $display("[TB] FAIL pcw_addr: got %h expected 00000104", a0); end
    m_instru = 32'h1234_5677; m_valid = 1'b1;
  endtask

  task automatic test_pc_write_during_req();
    logic [31:0] a0; bit st; int rc; bit ev;
    do_fetch(2, 32'hCAFE_0033, 1, 32'h200, 1'b0, a0, st, rc, ev);
    checks++; if (a0 !== 32'h104 || !st) begin errors++; $display("[TB] FAIL reqw_addr: got %h stable=%0d expected 00000104 stable=1", a0, st); end
    checks++; if (mem_addr !== 32'h104) begin errors++; $display("[TB] FAIL reqw_addr_after: got %h expected 00000104", mem_addr); end
    model_pc_write(32'h200);
    checks++; if (pc !== 32'h200) begin errors++; $display("[TB] FAIL reqw_pc: got %h expected 00000200", pc); end
    m_instru = 32'hCAFE_0033; m_valid = 1'b1;
  endtask

  task automatic test_pc_write_with_read();
    logic [31:0] a0; bit st; int rc; bit ev;
    logic [31:0] old_pc;
    old_pc = m_pc;
    do_fetch(0, 32'h0000_0067, -1, 32'h400, 1'b0, a0, st, rc, ev);
    model_pc_write(32'h400);
    checks++; if (a0 !== old_pc) begin errors++; $display("[TB] FAIL rdw_addr: got %h expected %h", a0, old_pc); end
    checks++; if (pc !== 32'h400) begin errors++; $display("[TB] FAIL rdw_pc: got %h expected 00000400", pc); end
    m_instru = 32'h0000_0067; m_valid = 1'b1;
    do_fetch(0, 32'h0000_0037, -2, 32'h0, 1'b0, a0, st, rc, ev);
    checks++; if (a0 !== 32'h400) begin errors++; $display("[TB] FAIL rdw_next_addr: got %h expected 00000400", a0); end
    m_instru = 32'h0000_0037; m_valid = 1'b1;
  endtask

  task automatic test_ignored_inputs();
    logic [31:0] a0; bit st; int rc; bit ev;
    // mem_ready while idle must not touch the IR
    mem_ready = 1'b1;
    repeat (2) begin
      mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    checks++; if (instru !== m_instru || instr_valid !== m_valid || mem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_ready: got %h v=%b req=%b expected %h v=%b req=0", instru, instr_valid, mem_req, m_instru, m_valid);
    end
    // imem_read held through REQ, including the completing cycle, must not start a new fetch
    do_fetch(2, 32'h0000_00EF, -2, 32'h0, 1'b1, a0, st, rc, ev);
    checks++; if (rc !== 3) begin errors++; $display("[TB] FAIL busy_read_cycles: got %0d expected 3", rc); end
    checks++; if (mem_req !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_read_restart: got req=%b expected 0", mem_req); end
    m_instru = 32'h0000_00EF; m_valid = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] a0; bit st; int rc; bit ev;
    logic [31:0] exp_addr, data, v;
    int waits, pwc;
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom;
        if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
        write_pc(v);
      end
      exp_addr = m_pc;
      waits = $urandom_range(0, 4);
      data  = $urandom;
      pwc   = $urandom_range(0, 3) == 0 ? -2 : int'($urandom_range(0, waits + 1)) - 1;
      v     = $urandom;
      do_fetch(waits, data, pwc, v, 1'b0, a0, st, rc, ev);
      if (pwc != -2) model_pc_write(v);
      m_instru = data; m_valid = 1'b1;
      checks++; if (a0 !== exp_addr || !st) begin errors++; $display("[TB] FAIL rnd_addr[%0d]: got %h stable=%0d expected %h", n, a0, st, exp_addr); end
      checks++; if (rc !== waits + 1 || ev) begin errors++; $display("[TB] FAIL rnd_req[%0d]: got cycles=%0d early=%0d expected cycles=%0d early=0", n, rc, ev, waits + 1); end
      checks++; if (instru !== m_instru || opcode !== m_instru[6:0] || instr_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL rnd_instru[%0d]: got %h v=%b expected %h v=1", n, instru, instr_valid, m_instru);
      end
      checks++; if (pc !== m_pc || fault_misaligned !== m_fault) begin
        errors++; $display("[TB] FAIL rnd_pc[%0d]: got %h f=%b expected %h f=%b", n, pc, fault_misaligned, m_pc, m_fault);
      end
    end
  endtask

  task automatic test_misaligned();
    write_pc(32'h102);
    checks++; if (pc !== 32'h100) begin errors++; $display("[TB] FAIL mis_pc: got %h expected 00000100", pc); end
    checks++; if (fault_misaligned !== 1'b1) begin errors++; $display("[TB] FAIL mis_fault: got %b expected 1", fault_misaligned); end
    write_pc(32'h300);
    write_pc(32'hFFFF_FFFC);
    checks++; if (fault_misaligned !== 1'b1 || pc !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL mis_sticky: got f=%b pc=%h expected f=1 pc=fffffffc", fault_misaligned, pc);
    end
  endtask

  task automatic test_reset_mid_req();
    imem_read = 1'b1;
    @(posedge clk); #1;
    imem_read = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_req: got %b expected 1", mem_req); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++; if (mem_req !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_req: got %b expected 0", mem_req); end
    checks++; if (instru !== NOP || instr_valid !== 1'b0 || pc !== m_pc || fault_misaligned !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_async_state: got %h v=%b pc=%h f=%b expected %h v=0 pc=%h f=0", instru, instr_valid, pc, fault_misaligned, NOP, m_pc);
    end
    reset     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    checks++; if (instru !== NOP || instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_late_ready: got %h v=%b req=%b expected %h v=0 req=0", instru, instr_valid, mem_req, NOP);
    end
  endtask

  initial begin
    reset     = 1'b1;
    imem_read = 1'b0;
    pc_write  = 1'b0;
    pc_next   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    model_reset();
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_pc_write_fetch();
    test_pc_write_during_req();
    test_pc_write_with_read();
    test_ignored_inputs();
    test_random();
    test_misaligned();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
